// File: rtl/ysyx_24100029_ifu_pkg.sv
// rtl/ysyx_24100029_ifu_pkg.sv - shared IFU types and constants
package ysyx_24100029_ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } ifu_state_e;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

endpackage

// File: rtl/ysyx_24100029_ifu_npc.sv
// rtl/ysyx_24100029_ifu_npc.sv - JAL predecode and next-PC adder
module ysyx_24100029_ifu_npc
  import ysyx_24100029_ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [6:0]  opcode,
  input  logic [19:0] imm_field,
  output logic [31:0] npc,
  output logic        pred_taken
);

  logic [31:0] imm_j;

  // imm_field is inst[31:12]; reassemble the scrambled J-type immediate
  assign imm_j      = {{12{imm_field[19]}}, imm_field[7:0], imm_field[8], imm_field[18:9], 1'b0};
  assign pred_taken = (opcode == OPC_JAL);
  assign npc        = pc + (pred_taken ? imm_j : 32'd4);

endmodule

// File: rtl/ysyx_24100029_ifu.sv
// rtl/ysyx_24100029_ifu.sv - instruction fetch unit with one outstanding request
module ysyx_24100029_ifu
  import ysyx_24100029_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        br_error,
  input  logic [31:0] br_npc,
  output logic        master_valid,
  input  logic        master_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        pred_res,
  output logic        inst_kill
);

  ifu_state_e  state;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic        pend;
  logic        redir;
  logic [31:0] redir_pc;
  logic        req_hs;
  logic        rsp_hs;
  logic [31:0] npc;
  logic        pred_taken;

  assign redir     = redirect_valid | br_error;
  assign redir_pc  = redirect_valid ? redirect_pc : br_npc;
  assign inst_kill = redir;

  assign req_valid = reset & (state == S_REQ);
  assign req_addr  = fetch_pc;
  assign rsp_ready = (state == S_FLUSH) | ((state == S_WAIT) & (~master_valid | master_ready));
  assign req_hs    = req_valid & req_ready;
  assign rsp_hs    = rsp_valid & rsp_ready;

  ysyx_24100029_ifu_npc u_npc (
    .pc         (fetch_pc),
    .opcode     (rsp_data[6:0]),
    .imm_field  (rsp_data[31:12]),
    .npc        (npc),
    .pred_taken (pred_taken)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_REQ;
      fetch_pc     <= RESET_PC;
      pend         <= 1'b0;
      pend_pc      <= 32'd0;
      master_valid <= 1'b0;
      inst         <= 32'd0;
      pc           <= 32'd0;
      pred_res     <= 1'b0;
    end else begin
      if (master_valid && master_ready) master_valid <= 1'b0;
      if (redir) master_valid <= 1'b0;

      case (state)
        S_REQ: begin
          // req_addr must stay put until accepted, so redirects wait in pend
          if (req_hs) begin
            if (redir) begin
              fetch_pc <= redir_pc;
              pend     <= 1'b0;
              state    <= S_FLUSH;
            end else if (pend) begin
              fetch_pc <= pend_pc;
              pend     <= 1'b0;
              state    <= S_FLUSH;
            end else begin
              state <= S_WAIT;
            end
          end else if (redir) begin
            pend    <= 1'b1;
            pend_pc <= redir_pc;
          end
        end
        S_WAIT: begin
          if (redir) begin
            fetch_pc <= redir_pc;
            state    <= rsp_hs ? S_REQ : S_FLUSH;
          end else if (rsp_hs) begin
            inst         <= rsp_data;
            pc           <= fetch_pc;
            pred_res     <= pred_taken;
            master_valid <= 1'b1;
            fetch_pc     <= npc;
            state        <= S_REQ;
          end
        end
        S_FLUSH: begin
          if (redir) fetch_pc <= redir_pc;
          if (rsp_hs) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_ifu.sv
// tb/tb_ysyx_24100029_ifu.sv - directed self-checking bench for the IFU
module tb_ysyx_24100029_ifu;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        br_error;
  logic [31:0] br_npc;
  logic        master_valid;
  logic        master_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        pred_res;
  logic        inst_kill;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] out_pc[$];
  logic [31:0] out_inst[$];
  logic        out_pred[$];

  int          rsp_delay;
  int          cnt;
  logic        busy;
  logic [31:0] pend_addr;

  ysyx_24100029_ifu #(.RESET_PC(32'h3000_0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .br_error       (br_error),
    .br_npc         (br_npc),
    .master_valid   (master_valid),
    .master_ready   (master_ready),
    .inst           (inst),
    .pc             (pc),
    .pred_res       (pred_res),
    .inst_kill      (inst_kill)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0013;
  endfunction

  // One clock: sample handshakes before the edge, update the memory model after it.
  task automatic tick();
    logic hs_req, hs_rsp;
    logic [31:0] a;
    #1;
    hs_req = req_valid & req_ready;
    hs_rsp = rsp_valid & rsp_ready;
    a      = req_addr;
    if (hs_req) begin
      req_log.push_back(a);
      req_cyc.push_back(cycle);
    end
    if (master_valid && master_ready) begin
      out_pc.push_back(pc);
      out_inst.push_back(inst);
      out_pred.push_back(pred_res);
    end
    @(posedge clock);
    cycle++;
    @(negedge clock);
    if (!reset) begin
      busy = 1'b0;
      rsp_valid = 1'b0;
    end else begin
      if (hs_rsp) begin
        rsp_valid = 1'b0;
        busy = 1'b0;
      end
      if (hs_req) begin
        busy = 1'b1;
        cnt = rsp_delay;
        pend_addr = a;
      end
      if (busy && !rsp_valid) begin
        if (cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data = word(pend_addr);
        end else begin
          cnt--;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_data = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    br_error = 1'b0;
    br_npc = 32'd0;
    master_ready = 1'b1;
    rsp_delay = 0;
    busy = 1'b0;
    cnt = 0;
    mem.delete();
    req_log.delete();
    req_cyc.delete();
    out_pc.delete();
    out_inst.delete();
    out_pred.delete();
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic run_until_reqs(input string name, input int n);
    int budget = 60;
    while (req_log.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (req_log.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d requests, need %0d", name, req_log.size(), n);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
    checks++; if (master_valid !== 1'b0) begin errors++; $display("FAIL reset_master_valid: got %b expected 0", master_valid); end
    checks++; if (inst !== 32'd0 || pc !== 32'd0 || pred_res !== 1'b0) begin errors++; $display("FAIL reset_outputs: got inst=%h pc=%h pred=%b expected zeros", inst, pc, pred_res); end
    do_reset();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h3000_0000) begin errors++; $display("FAIL reset_first_req: got valid=%b addr=%h expected 1/30000000", req_valid, req_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    run_until_reqs("seq", 2);
    if (req_log.size() >= 2) begin
      checks++; if (req_log[0] !== 32'h3000_0000 || req_log[1] !== 32'h3000_0004) begin errors++; $display("FAIL seq_addrs: got %h %h expected 30000000 30000004", req_log[0], req_log[1]); end
      checks++; if (req_cyc[1] - req_cyc[0] != 2) begin errors++; $display("FAIL seq_throughput: got %0d cycles expected 2", req_cyc[1] - req_cyc[0]); end
    end
    checks++;
    if (out_pc.size() < 1 || out_pc[0] !== 32'h3000_0000 || out_pred[0] !== 1'b0 || out_inst[0] !== 32'h0000_0013) begin
      errors++;
      $display("FAIL seq_output: got %0d outputs expected pc=30000000 inst=00000013 pred=0", out_pc.size());
    end
  endtask

  task automatic test_jal();
    do_reset();
    mem[32'h3000_0000] = 32'h0080_006F;
    mem[32'h3000_0008] = 32'hFF9F_F06F;
    run_until_reqs("jal", 3);
    if (req_log.size() >= 3) begin
      checks++; if (req_log[1] !== 32'h3000_0008) begin errors++; $display("FAIL jal_fwd_addr: got %h expected 30000008", req_log[1]); end
      checks++; if (req_log[2] !== 32'h3000_0000) begin errors++; $display("FAIL jal_back_addr: got %h expected 30000000", req_log[2]); end
    end
    checks++;
    if (out_pc.size() < 2 || out_pred[0] !== 1'b1 || out_pred[1] !== 1'b1 || out_pc[1] !== 32'h3000_0008) begin
      errors++;
      $display("FAIL jal_pred: got %0d outputs expected pred=1 twice, second pc=30000008", out_pc.size());
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    rsp_delay = 2;
    mem[32'h3000_0000] = 32'h0080_006F;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0000;
    #1;
    checks++; if (inst_kill !== 1'b1) begin errors++; $display("FAIL redir_kill_on: got %b expected 1", inst_kill); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (inst_kill !== 1'b0) begin errors++; $display("FAIL redir_kill_off: got %b expected 0", inst_kill); end
    checks++; if (req_valid !== 1'b0 || rsp_ready !== 1'b1) begin errors++; $display("FAIL redir_flush_state: got req_valid=%b rsp_ready=%b expected 0/1", req_valid, rsp_ready); end
    repeat (2) tick();
    checks++; if (master_valid !== 1'b0) begin errors++; $display("FAIL redir_discard: got master_valid=%b expected 0", master_valid); end
    run_until_reqs("redir", 2);
    if (req_log.size() >= 2) begin
      checks++; if (req_log[1] !== 32'h8000_0000) begin errors++; $display("FAIL redir_target: got %h expected 80000000", req_log[1]); end
    end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0000;
    br_error = 1'b1;
    br_npc = 32'h3000_0100;
    tick();
    redirect_valid = 1'b0;
    br_error = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin errors++; $display("FAIL prio_target: got valid=%b addr=%h expected 1/80000000", req_valid, req_addr); end
    checks++; if (master_valid !== 1'b0) begin errors++; $display("FAIL prio_dropped: got master_valid=%b expected 0", master_valid); end
  endtask

  task automatic test_pending();
    do_reset();
    req_ready = 1'b0;
    repeat (2) tick();
    br_error = 1'b1;
    br_npc = 32'h3000_0100;
    tick();
    br_error = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h3000_0000) begin errors++; $display("FAIL pend_hold: got valid=%b addr=%h expected 1/30000000", req_valid, req_addr); end
    req_ready = 1'b1;
    run_until_reqs("pend", 3);
    if (req_log.size() >= 2) begin
      checks++; if (req_log[1] !== 32'h3000_0100) begin errors++; $display("FAIL pend_target: got %h expected 30000100", req_log[1]); end
    end
    checks++;
    if (out_pc.size() < 1 || out_pc[0] !== 32'h3000_0100) begin
      errors++;
      $display("FAIL pend_first_out: got %0d outputs expected first pc=30000100", out_pc.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_pc, held_inst;
    do_reset();
    mem[32'h3000_0000] = 32'h0010_0093;
    mem[32'h3000_0004] = 32'h0020_0113;
    master_ready = 1'b0;
    repeat (3) tick();
    held_pc = pc;
    held_inst = inst;
    checks++; if (held_pc !== 32'h3000_0000 || held_inst !== 32'h0010_0093) begin errors++; $display("FAIL bp_loaded: got pc=%h inst=%h expected 30000000/00100093", held_pc, held_inst); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (master_valid !== 1'b1 || pc !== 32'h3000_0000 || inst !== 32'h0010_0093 || rsp_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got mv=%b pc=%h inst=%h rsp_ready=%b", i, master_valid, pc, inst, rsp_ready);
      end
    end
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL bp_no_extra_req: got %0d requests expected 2", req_log.size()); end
    master_ready = 1'b1;
    tick();
    checks++; if (pc !== 32'h3000_0004 || inst !== 32'h0020_0113 || master_valid !== 1'b1) begin errors++; $display("FAIL bp_release: got pc=%h inst=%h mv=%b expected 30000004/00200113/1", pc, inst, master_valid); end
    checks++; if (out_pc.size() != 1) begin errors++; $display("FAIL bp_consumed: got %0d outputs expected 1", out_pc.size()); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start: got %h expected fffffffc", req_addr); end
    run_until_reqs("wrap", 3);
    if (req_log.size() >= 3) begin
      checks++; if (req_log[2] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", req_log[2]); end
    end
    checks++;
    if (out_pc.size() < 1 || out_pc[0] !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_out_pc: got %0d outputs expected pc=fffffffc", out_pc.size());
    end
    reset = 1'b0;
    rsp_valid = 1'b0;
    busy = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b0 || master_valid !== 1'b0 || pc !== 32'd0 || inst !== 32'd0) begin errors++; $display("FAIL midreset_clear: got rv=%b mv=%b pc=%h inst=%h expected all 0", req_valid, master_valid, pc, inst); end
    checks++; if (req_addr !== 32'h3000_0000) begin errors++; $display("FAIL midreset_pc: got %h expected 30000000", req_addr); end
    tick();
    checks++; if (req_log.size() != 3) begin errors++; $display("FAIL midreset_no_req: got %0d requests expected 3", req_log.size()); end
    reset = 1'b1;
    #1;
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h3000_0000) begin errors++; $display("FAIL midreset_resume: got valid=%b addr=%h expected 1/30000000", req_valid, req_addr); end
    tick();
    checks++;
    if (req_log.size() != 4 || req_log[req_log.size()-1] !== 32'h3000_0000) begin
      errors++;
      $display("FAIL midreset_first_req: got %0d requests expected 4 ending 30000000", req_log.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    br_error = 1'b0;
    br_npc = 32'd0;
    master_ready = 1'b0;
    rsp_delay = 0;
    busy = 1'b0;
    cnt = 0;
    pend_addr = 32'd0;
    test_reset();
    test_sequential();
    test_jal();
    test_redirect_wait();
    test_redirect_priority();
    test_pending();
    test_backpressure();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
